// File: rtl/sram_bist_ctrl.sv
// March C- BIST initiator for a single-port synchronous SRAM.
// Runs six March elements back-to-back and captures the first read mismatch.
module sram_bist_ctrl #(
   parameter int MEM_DEPTH  = 8192,
   parameter int DATA_WIDTH = 8,
   parameter int BITW       = $clog2(MEM_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic                  fail,
   output logic [BITW-1:0]       fail_addr,
   output logic [DATA_WIDTH-1:0] fail_data,
   output logic [2:0]            fail_elem,
   output logic                  sram_csn,
   output logic                  sram_we,
   output logic [BITW-1:0]       sram_addr,
   output logic [DATA_WIDTH-1:0] sram_din,
   input  logic [DATA_WIDTH-1:0] sram_dout
);

   typedef enum logic [3:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH, S_DONE
   } state_t;

   localparam logic [BITW-1:0]       LAST_ADDR = BITW'(MEM_DEPTH - 1);
   localparam logic [BITW-1:0]       ONE_ADDR  = BITW'(1);
   localparam logic [DATA_WIDTH-1:0] BG0       = '0;
   localparam logic [DATA_WIDTH-1:0] BG1       = '1;

   state_t                  state_reg;
   logic [BITW-1:0]         addr_reg;
   logic                    csn_reg;
   logic                    we_reg;
   logic [DATA_WIDTH-1:0]   din_reg;
   logic                    busy_reg;
   logic                    done_reg;
   logic                    fail_reg;
   logic [BITW-1:0]         fail_addr_reg;
   logic [DATA_WIDTH-1:0]   fail_data_reg;
   logic [2:0]              fail_elem_reg;

   // Compare stage: describes the read whose data is on sram_dout this cycle.
   logic                    cmp_pend_reg;
   logic [DATA_WIDTH-1:0]   cmp_exp_reg;
   logic [BITW-1:0]         cmp_addr_reg;
   logic [2:0]              cmp_elem_reg;

   logic                    rd_cycle;
   logic [2:0]              cur_elem;
   logic [DATA_WIDTH-1:0]   cur_exp;
   logic [DATA_WIDTH-1:0]   bit_miss;
   logic                    mismatch;
   logic                    at_last;
   logic                    at_first;

   assign rd_cycle = !csn_reg && !we_reg;
   assign at_last  = (addr_reg == LAST_ADDR);
   assign at_first = (addr_reg == '0);

   always_comb begin
      cur_elem = 3'd0;
      cur_exp  = BG0;
      case (state_reg)
         S_M1: cur_elem = 3'd1;
         S_M2: begin
            cur_elem = 3'd2;
            cur_exp  = BG1;
         end
         S_M3: cur_elem = 3'd3;
         S_M4: begin
            cur_elem = 3'd4;
            cur_exp  = BG1;
         end
         S_M5: cur_elem = 3'd5;
         default: begin
            cur_elem = 3'd0;
            cur_exp  = BG0;
         end
      endcase
   end

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_cmp
         assign bit_miss[gi] = sram_dout[gi] ^ cmp_exp_reg[gi];
      end
   endgenerate

   assign mismatch = cmp_pend_reg && (|bit_miss);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= S_IDLE;
         addr_reg      <= '0;
         csn_reg       <= 1'b1;
         we_reg        <= 1'b0;
         din_reg       <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         fail_reg      <= 1'b0;
         fail_addr_reg <= '0;
         fail_data_reg <= '0;
         fail_elem_reg <= 3'd0;
         cmp_pend_reg  <= 1'b0;
         cmp_exp_reg   <= '0;
         cmp_addr_reg  <= '0;
         cmp_elem_reg  <= 3'd0;
      end else begin
         cmp_pend_reg <= rd_cycle;
         cmp_exp_reg  <= cur_exp;
         cmp_addr_reg <= addr_reg;
         cmp_elem_reg <= cur_elem;

         if (mismatch && !fail_reg) begin
            fail_reg      <= 1'b1;
            fail_addr_reg <= cmp_addr_reg;
            fail_data_reg <= sram_dout;
            fail_elem_reg <= cmp_elem_reg;
         end

         // In M1..M4 the registered we doubles as the read/write phase.
         case (state_reg)
            S_IDLE, S_DONE: begin
               if (start) begin
                  state_reg     <= S_M0;
                  addr_reg      <= '0;
                  csn_reg       <= 1'b0;
                  we_reg        <= 1'b1;
                  din_reg       <= BG0;
                  busy_reg      <= 1'b1;
                  done_reg      <= 1'b0;
                  fail_reg      <= 1'b0;
                  fail_addr_reg <= '0;
                  fail_data_reg <= '0;
                  fail_elem_reg <= 3'd0;
               end
            end
            S_M0: begin
               if (at_last) begin
                  state_reg <= S_M1;
                  addr_reg  <= '0;
                  we_reg    <= 1'b0;
               end else begin
                  addr_reg <= addr_reg + ONE_ADDR;
               end
            end
            S_M1: begin
               if (!we_reg) begin
                  we_reg  <= 1'b1;
                  din_reg <= BG1;
               end else begin
                  we_reg <= 1'b0;
                  if (at_last) begin
                     state_reg <= S_M2;
                     addr_reg  <= '0;
                  end else begin
                     addr_reg <= addr_reg + ONE_ADDR;
                  end
               end
            end
            S_M2: begin
               if (!we_reg) begin
                  we_reg  <= 1'b1;
                  din_reg <= BG0;
               end else begin
                  we_reg <= 1'b0;
                  if (at_last) begin
                     state_reg <= S_M3;
                     addr_reg  <= LAST_ADDR;
                  end else begin
                     addr_reg <= addr_reg + ONE_ADDR;
                  end
               end
            end
            S_M3: begin
               if (!we_reg) begin
                  we_reg  <= 1'b1;
                  din_reg <= BG1;
               end else begin
                  we_reg <= 1'b0;
                  if (at_first) begin
                     state_reg <= S_M4;
                     addr_reg  <= LAST_ADDR;
                  end else begin
                     addr_reg <= addr_reg - ONE_ADDR;
                  end
               end
            end
            S_M4: begin
               if (!we_reg) begin
                  we_reg  <= 1'b1;
                  din_reg <= BG0;
               end else begin
                  we_reg <= 1'b0;
                  if (at_first) begin
                     state_reg <= S_M5;
                     addr_reg  <= '0;
                  end else begin
                     addr_reg <= addr_reg - ONE_ADDR;
                  end
               end
            end
            S_M5: begin
               if (at_last) begin
                  state_reg <= S_FLUSH;
                  csn_reg   <= 1'b1;
                  we_reg    <= 1'b0;
               end else begin
                  addr_reg <= addr_reg + ONE_ADDR;
               end
            end
            S_FLUSH: begin
               state_reg <= S_DONE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b1;
            end
            default: begin
               state_reg <= S_IDLE;
               csn_reg   <= 1'b1;
               we_reg    <= 1'b0;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = busy_reg;
   assign done      = done_reg;
   assign fail      = fail_reg;
   assign fail_addr = fail_addr_reg;
   assign fail_data = fail_data_reg;
   assign fail_elem = fail_elem_reg;
   assign sram_csn  = csn_reg;
   assign sram_we   = we_reg;
   assign sram_addr = addr_reg;
   assign sram_din  = din_reg;

endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
March C- built-in self-test engine that acts as the initiator on the single-port SRAM interface (csn/we/addr/din/dout). It drives every address with the six March C- elements, compares read data against expected background, and reports pass/fail with first-failure capture. It sits beside the SRAM macro and owns its port while busy. It is muxed off by the integration level when not testing.

Parameters:
MEM_DEPTH, 8192, number of SRAM words tested (addresses 0..MEM_DEPTH-1)
DATA_WIDTH, 8, SRAM word width; background 0 = all zeros, background 1 = all ones
BITW, $clog2(MEM_DEPTH), address width

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin test; sampled only in IDLE/DONE
busy  output  1  high from first SRAM access through final compare
done  output  1  high in DONE, held until next accepted start
fail  output  1  sticky mismatch flag, valid with done, cleared on accepted start
fail_addr  output  BITW  address of first mismatch
fail_data  output  DATA_WIDTH  read data at first mismatch
fail_elem  output  3  March element index (1..5) of first mismatch
sram_csn  output  1  SRAM chip select, active low
sram_we  output  1  SRAM write enable (1 = write)
sram_addr  output  BITW  SRAM address
sram_din  output  DATA_WIDTH  SRAM write data
sram_dout  input  DATA_WIDTH  SRAM read data, valid the cycle after a read access

Behaviour:
- Reset (async, rst_n=0): state IDLE; sram_csn=1, sram_we=0, sram_addr=0, sram_din=0, busy=0, done=0, fail=0, fail_addr=0, fail_data=0, fail_elem=0. Reset mid-test aborts immediately; no further SRAM access.
- States: IDLE, M0, M1, M2, M3, M4, M5, FLUSH, DONE.
- start=1 in IDLE or DONE at edge k: clear done/fail/capture regs; next cycle enters M0 at addr 0 with csn=0. start while busy ignored.
- M0 (up): w0, one cycle per address.
- M1 (up): r0 then w1; M2 (up): r1 then w0; M3 (down, MEM_DEPTH-1..0): r0 then w1; M4 (down): r1 then w0. Read cycle: csn=0, we=0; write cycle: csn=0, we=1, same address.
- M5 (up): r0, one cycle per address.
- Element transitions are back-to-back, no idle cycles; address wraps from the last address to the next element's start address.
- Compare pipeline: every read registers expected data and address/element; comparison happens on the following edge against sram_dout. sram_dout is ignored in all other cycles because the SRAM drives X when deselected.
- FLUSH: one cycle after the last M5 read, csn=1, performs the final compare, then DONE.
- Total: 10*MEM_DEPTH access cycles + 1 FLUSH cycle; busy high for exactly those cycles; done rises on the following edge.
- First mismatch latches fail=1, fail_addr, fail_data, fail_elem; later mismatches do not overwrite. The test always runs to completion.
- DONE: csn=1, done=1, results stable until next accepted start.
- csn=1 and we=0 in IDLE, FLUSH and DONE.

Test Plan:
- MEM_DEPTH=16, fault-free SRAM model, start pulse -> busy high 161 cycles, done=1, fail=0; access trace is 16 w0, 16×(r0,w1) ascending, …, 16 r0; memory ends all 8'h00.
- SRAM model with bit 3 stuck-at-1 at addr 5 -> done=1, fail=1, fail_addr=5, fail_data=8'h08, fail_elem=1.
- Coupling fault (write 1 to addr 9 flips addr 4 to 8'hFF) -> first mismatch captured in M3 or M5 per March order; the bench checks fail_elem/addr against reference model and confirms later mismatches do not overwrite capture.
- start pulsed at cycles 10 and 50 of a run -> ignored; run length unchanged; second start after done -> results cleared, full rerun.
- rst_n deasserted at cycle 40 mid-M1 -> outputs at reset values asynchronously; csn=1; after release no access until start.
- Boundary: MEM_DEPTH=16, check M3 begins at addr 15 immediately after M2 ends at addr 15; the final M5 read at addr 15 is compared in FLUSH (fault injected there -> fail_elem=5, fail_addr=15).
